// File: rtl/reg_file_sb_if.sv
// Bus bundle between the register file and its write-back / issue / decode clients.
interface reg_file_sb_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              issue_en;
   logic [ADDR_W-1:0] issue_addr;
   logic [ADDR_W-1:0] rd_addr_a;
   logic [DATA_W-1:0] rd_data_a;
   logic              busy_a;
   logic [ADDR_W-1:0] rd_addr_b;
   logic [DATA_W-1:0] rd_data_b;
   logic              busy_b;

   modport master (
      output wr_en, wr_addr, wr_data, issue_en, issue_addr, rd_addr_a, rd_addr_b,
      input  rd_data_a, busy_a, rd_data_b, busy_b
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, issue_en, issue_addr, rd_addr_a, rd_addr_b,
      output rd_data_a, busy_a, rd_data_b, busy_b
   );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with two combinational read ports, one write port with
// write-through bypass, r0 hardwired to zero, and a per-register busy
// scoreboard used by decode to stall on RAW hazards.
module reg_file_sb #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input logic          clk,
   input logic          rst_n,
   reg_file_sb_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic              wr_hit;
   logic              issue_hit;

   assign wr_hit    = bus.wr_en    && (bus.wr_addr    != '0);
   assign issue_hit = bus.issue_en && (bus.issue_addr != '0);

   // Register storage: async clear, writes to r0 discarded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else if (wr_hit) begin
         regs[bus.wr_addr] <= bus.wr_data;
      end
   end

   // Scoreboard: clear on write-back, then set on issue so a newer producer wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
      end else begin
         if (wr_hit)    busy[bus.wr_addr]    <= 1'b0;
         if (issue_hit) busy[bus.issue_addr] <= 1'b1;
      end
   end

   // Port A read: r0 reads zero, bypass the in-flight write, otherwise array.
   // Reset forces zero so the bypass cannot leak wr_data while held.
   always_comb begin
      bus.rd_data_a = '0;
      bus.busy_a    = 1'b0;
      if (rst_n && (bus.rd_addr_a != '0)) begin
         if (bus.wr_en && (bus.wr_addr == bus.rd_addr_a)) begin
            bus.rd_data_a = bus.wr_data;
         end else begin
            bus.rd_data_a = regs[bus.rd_addr_a];
            bus.busy_a    = busy[bus.rd_addr_a];
         end
      end
   end

   // Port B read: identical to port A.
   always_comb begin
      bus.rd_data_b = '0;
      bus.busy_b    = 1'b0;
      if (rst_n && (bus.rd_addr_b != '0)) begin
         if (bus.wr_en && (bus.wr_addr == bus.rd_addr_b)) begin
            bus.rd_data_b = bus.wr_data;
         end else begin
            bus.rd_data_b = regs[bus.rd_addr_b];
            bus.busy_b    = busy[bus.rd_addr_b];
         end
      end
   end
endmodule
